mrv1_th_barrier_ctl: RTL
========================

// Module: mrv1_th_barrier_ctl
// PURPOSE
//  Barrier controller for the IMT thread scheduler. Collects per-barrier arrivals from the thread-control unit.
//  Holds a blocked-thread mask that the scheduler ANDs out of its ready set.
//  When a barrier's arrival count reaches size, the barrier releases its waiters one barrier per handshake.
//  Sits between th_ctl (arrivals) and mrv1_th_sched (blocked mask, release).
// PARAMETERS
//  NUM_THREADS_P        8                      hardware threads
//  num_barriers_p       8                      independent barriers
//  tid_width_lp         $clog2(NUM_THREADS_P)  thread id width (local)
//  barrier_id_width_lp  $clog2(num_barriers_p) barrier id width (local)
// PORTS
//  clk_i            in   1                    single clock, all state on posedge
//  rst_i            in   1                    synchronous, active-high reset
//  arr_vld_i        in   1                    barrier arrival request
//  arr_rdy_o        out  1                    arrival accepted when arr_vld_i & arr_rdy_o
//  arr_id_i         in   barrier_id_width_lp  target barrier
//  arr_tid_i        in   tid_width_lp         arriving thread
//  arr_size_m1_i    in   tid_width_lp         barrier participant count minus 1
//  blocked_o        out  NUM_THREADS_P        OR of all barriers' waiter masks (registered)
//  rel_vld_o        out  1                    a barrier release is offered
//  rel_rdy_i        in   1                    scheduler accepts release
//  rel_id_o         out  barrier_id_width_lp  released barrier
//  rel_mask_o       out  NUM_THREADS_P        threads to unblock
//  err_o            out  1                    1-cycle pulse: protocol violation on accepted arrival
// BEHAVIOUR
//  - Per barrier b: state {IDLE, COLLECT, RELEASE}, size_q (tid_width_lp), cnt_q (tid_width_lp+1), mask_q.
//  - Reset: all barriers IDLE, cnt/mask/size 0; blocked_o=0, rel_vld_o=0, err_o=0. Mid-operation reset drops all waiters.
//  - arr_rdy_o = (state[arr_id_i] != RELEASE); combinational from state only.
//  - Accepted arrival, barrier IDLE: latch size_q=arr_size_m1_i, cnt=1, set mask bit -> COLLECT;
//    if arr_size_m1_i==0 -> RELEASE directly.
//  - Accepted arrival, COLLECT, new thread: cnt+1, set mask bit; if cnt+1 == size_q+1 -> RELEASE.
//  - Duplicate arrival (mask bit already set): err_o pulses next cycle; not counted, state unchanged.
//  - Size mismatch (arr_size_m1_i != size_q in COLLECT): err_o pulses; arrival still counted with latched size_q.
//  - Arrival id >= num_barriers_p (non-power-of-2 counts): err_o pulses, arrival dropped.
//  - Latency: arrival accepted in cycle N -> blocked_o bit set and state updated at N+1.
//    Completing arrival -> rel_vld_o may assert at N+1.
//  - Release arbiter: round-robin over barriers in RELEASE; pointer advances past winner on handshake only.
//    rel_id_o/rel_mask_o stable while rel_vld_o & ~rel_rdy_i.
//  - On rel_vld_o & rel_rdy_i in cycle M: barrier -> IDLE, mask/cnt cleared.
//    blocked_o drops those bits at M+1; the barrier accepts new arrivals from M+1.
//  - Arrival to a barrier in RELEASE is back-pressured (arr_rdy_o=0), never dropped.
//  - Simultaneous arrival to barrier A and release of barrier B (A!=B): both take effect.
//  - cnt never wraps: max value NUM_THREADS_P fits tid_width_lp+1 bits.
// TESTING
//  - Reset then idle -> blocked_o=0, rel_vld_o=0, arr_rdy_o=1, err_o=0.
//  - Barrier 2, size_m1=3, tids 0,1,2,3 on consecutive cycles, rel_rdy_i=1:
//    -> blocked_o 0x01,0x03,0x07,0x0F; rel_vld_o the cycle after tid3 with id=2, mask=0x0F;
//    -> blocked_o=0 the following cycle.
//  - Barriers 1 and 5 complete in the same cycle, rel_rdy_i=1 -> releases on consecutive cycles (1 then 5);
//    with pointer past 1, the next simultaneous pair releases 5 first.
//  - rel_rdy_i=0 for 3 cycles with barrier 0 pending -> rel_vld_o held and outputs stable;
//    arrival to barrier 0 sees arr_rdy_o=0; accepted after the handshake.
//  - Duplicate tid 4 to barrier 3 -> err_o pulse, cnt unchanged.
//    size_m1 mismatch -> err_o pulse, count advances; size_m1=0 -> release the cycle after arrival.
//  - Assert rst_i while barrier 6 holds mask 0x30 -> next cycle blocked_o=0, all barriers IDLE.

Source files
------------

// File: rtl/mrv1_th_barrier_ctl.sv
// Barrier controller for the IMT thread scheduler.
// Tracks per-barrier arrivals, blocked threads and round-robin release.
module mrv1_th_barrier_ctl #(
   parameter int NUM_THREADS_P  = 8,
   parameter int num_barriers_p = 8,
   localparam int tid_width_lp =
      (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1,
   localparam int barrier_id_width_lp =
      (num_barriers_p > 1) ? $clog2(num_barriers_p) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           arr_vld_i,
   output logic                           arr_rdy_o,
   input  logic [barrier_id_width_lp-1:0] arr_id_i,
   input  logic [tid_width_lp-1:0]        arr_tid_i,
   input  logic [tid_width_lp-1:0]        arr_size_m1_i,
   output logic [NUM_THREADS_P-1:0]       blocked_o,
   output logic                           rel_vld_o,
   input  logic                           rel_rdy_i,
   output logic [barrier_id_width_lp-1:0] rel_id_o,
   output logic [NUM_THREADS_P-1:0]       rel_mask_o,
   output logic                           err_o
);

   localparam int cnt_width_lp = tid_width_lp + 1;
   localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RELEASE = 2'd2
   } bar_st_e;

   bar_st_e                  st_q   [num_barriers_p];
   bar_st_e                  st_d   [num_barriers_p];
   logic [tid_width_lp-1:0]  size_q [num_barriers_p];
   logic [tid_width_lp-1:0]  size_d [num_barriers_p];
   logic [cnt_width_lp-1:0]  cnt_q  [num_barriers_p];
   logic [cnt_width_lp-1:0]  cnt_d  [num_barriers_p];
   logic [NUM_THREADS_P-1:0] mask_q [num_barriers_p];
   logic [NUM_THREADS_P-1:0] mask_d [num_barriers_p];

   logic [NUM_THREADS_P-1:0] blocked_q;
   logic [NUM_THREADS_P-1:0] blocked_d;
   logic                     err_q;
   logic                     err_d;

   logic [barrier_id_width_lp-1:0] ptr_q;
   logic [barrier_id_width_lp-1:0] ptr_d;
   logic                           lock_vld_q;
   logic                           lock_vld_d;
   logic [barrier_id_width_lp-1:0] lock_id_q;
   logic [barrier_id_width_lp-1:0] lock_id_d;

   logic                           arr_ok;
   logic                           arr_fire;
   logic                           rr_vld;
   logic [barrier_id_width_lp-1:0] rr_id;
   logic [barrier_id_width_lp-1:0] cand;
   logic [barrier_id_width_lp-1:0] win_id;
   logic                           rel_vld;
   logic                           rel_fire;
   logic [NUM_THREADS_P-1:0]       tid_bit;
   logic [cnt_width_lp-1:0]        cnt_inc;

   // Out-of-range ids are never back-pressured so they can be flagged.
   always_comb begin
      arr_ok    = int'(arr_id_i) < num_barriers_p;
      arr_rdy_o = 1'b1;
      if (arr_ok) begin
         arr_rdy_o = (st_q[arr_id_i] != RELEASE);
      end
      arr_fire = arr_vld_i & arr_rdy_o;
      tid_bit  = NUM_THREADS_P'(1) << arr_tid_i;
   end

   always_comb begin
      rr_vld = 1'b0;
      rr_id  = '0;
      cand   = '0;
      for (int i = 0; i < num_barriers_p; i++) begin
         cand = barrier_id_width_lp'(
            (int'(ptr_q) + i) % num_barriers_p);
         if (!rr_vld && st_q[cand] == RELEASE) begin
            rr_vld = 1'b1;
            rr_id  = cand;
         end
      end
   end

   // A stalled offer stays locked so id/mask cannot change under it.
   always_comb begin
      win_id   = lock_vld_q ? lock_id_q : rr_id;
      rel_vld  = lock_vld_q | rr_vld;
      rel_fire = rel_vld & rel_rdy_i;
   end

   assign rel_vld_o  = rel_vld;
   assign rel_id_o   = win_id;
   assign rel_mask_o = mask_q[win_id];
   assign blocked_o  = blocked_q;
   assign err_o      = err_q;

   always_comb begin
      for (int b = 0; b < num_barriers_p; b++) begin
         st_d[b]   = st_q[b];
         size_d[b] = size_q[b];
         cnt_d[b]  = cnt_q[b];
         mask_d[b] = mask_q[b];
      end
      err_d      = 1'b0;
      ptr_d      = ptr_q;
      lock_vld_d = 1'b0;
      lock_id_d  = lock_id_q;
      cnt_inc    = '0;
      blocked_d  = '0;

      if (rel_fire) begin
         st_d[win_id]   = IDLE;
         cnt_d[win_id]  = '0;
         mask_d[win_id] = '0;
         ptr_d = barrier_id_width_lp'(
            (int'(win_id) + 1) % num_barriers_p);
      end else if (rel_vld) begin
         lock_vld_d = 1'b1;
         lock_id_d  = win_id;
      end

      // Releases only hit RELEASE barriers and arrivals never do.
      if (arr_fire) begin
         if (!arr_ok) begin
            err_d = 1'b1;
         end else begin
            cnt_inc = cnt_q[arr_id_i] + cnt_one_lp;
            unique case (st_q[arr_id_i])
               IDLE: begin
                  size_d[arr_id_i] = arr_size_m1_i;
                  cnt_d[arr_id_i]  = cnt_one_lp;
                  mask_d[arr_id_i] = tid_bit;
                  st_d[arr_id_i]   = (arr_size_m1_i == '0) ?
                                     RELEASE : COLLECT;
               end
               COLLECT: begin
                  if (|(mask_q[arr_id_i] & tid_bit)) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = (arr_size_m1_i != size_q[arr_id_i]);
                     cnt_d[arr_id_i]  = cnt_inc;
                     mask_d[arr_id_i] = mask_q[arr_id_i] | tid_bit;
                     if (cnt_inc ==
                         cnt_width_lp'(size_q[arr_id_i]) + cnt_one_lp)
                     begin
                        st_d[arr_id_i] = RELEASE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      for (int b = 0; b < num_barriers_p; b++) begin
         blocked_d = blocked_d | mask_d[b];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < num_barriers_p; b++) begin
            st_q[b]   <= IDLE;
            size_q[b] <= '0;
            cnt_q[b]  <= '0;
            mask_q[b] <= '0;
         end
         blocked_q  <= '0;
         err_q      <= 1'b0;
         ptr_q      <= '0;
         lock_vld_q <= 1'b0;
         lock_id_q  <= '0;
      end else begin
         for (int b = 0; b < num_barriers_p; b++) begin
            st_q[b]   <= st_d[b];
            size_q[b] <= size_d[b];
            cnt_q[b]  <= cnt_d[b];
            mask_q[b] <= mask_d[b];
         end
         blocked_q  <= blocked_d;
         err_q      <= err_d;
         ptr_q      <= ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
      end
   end

endmodule
